// File: rtl/msg_gen_hex.sv
// Response-line generator: streams a ROM text span, an optional hex rendering of
// a DW-bit result and a CR/LF (or LF-only) terminator to the UART TX front end.
module msg_gen_hex #(
    parameter int AW          = 7,
    parameter int DW          = 64,
    parameter int EOL_LF_ONLY = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          res_rdy_t_i,
    input  logic [2:0]    res_mode_i,
    input  logic [AW-1:0] res_start_i,
    input  logic [AW-1:0] res_end_i,
    input  logic [DW-1:0] res_val_i,
    output logic          res_rdy_r_o,
    output logic [AW-1:0] addr_o,
    input  logic [7:0]    data_i,
    output logic          tx_rdy_t_o,
    output logic [7:0]    tx_data_t_o,
    input  logic          tx_rdy_r_i
);
    localparam int ND = DW / 4;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ND - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_TMEM, S_THEX, S_TCR, S_TLF
    } state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] end_q;
    logic [DW-1:0] val_q;
    logic [2:0]    mode_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    tx_data_q;
    logic          tx_rdy_q;
    logic          res_rdy_q;

    logic [IW-1:0] lz_idx_d;
    logic [IW-1:0] idx_inc_d;
    logic [DW-1:0] cur_sh_d;
    logic [DW-1:0] nxt_sh_d;
    logic [7:0]    cur_char_d;
    logic [7:0]    nxt_char_d;
    logic          is_hex_d;
    logic          xfer_d;
    logic [7:0]    eol_first_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Index of the most significant non-zero nibble; the last digit when the value is zero.
    always_comb begin
        lz_idx_d = LAST_IDX;
        for (int i = ND - 1; i >= 0; i--) begin
            if (res_val_i[DW-1-4*i -: 4] != 4'd0) lz_idx_d = IW'(i);
        end
    end

    always_comb begin
        idx_inc_d   = idx_q + IW'(1);
        cur_sh_d    = val_q << {idx_q, 2'b00};
        nxt_sh_d    = val_q << {idx_inc_d, 2'b00};
        cur_char_d  = hex_ascii(cur_sh_d[DW-1 -: 4]);
        nxt_char_d  = hex_ascii(nxt_sh_d[DW-1 -: 4]);
        is_hex_d    = (mode_q == 3'b001) || (mode_q == 3'b010);
        xfer_d      = tx_rdy_q & tx_rdy_r_i;
        eol_first_d = (EOL_LF_ONLY != 0) ? 8'h0A : 8'h0D;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            end_q     <= '0;
            val_q     <= '0;
            mode_q    <= '0;
            idx_q     <= '0;
            tx_data_q <= 8'h00;
            tx_rdy_q  <= 1'b0;
            res_rdy_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (res_rdy_t_i && res_rdy_q) begin
                        addr_q    <= res_start_i;
                        end_q     <= res_end_i;
                        val_q     <= res_val_i;
                        mode_q    <= res_mode_i;
                        idx_q     <= (res_mode_i == 3'b010) ? lz_idx_d : '0;
                        res_rdy_q <= 1'b0;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    tx_data_q <= data_i;
                    tx_rdy_q  <= 1'b1;
                    state_q   <= S_TMEM;
                end
                S_TMEM: begin
                    if (xfer_d) begin
                        if (addr_q != end_q) begin
                            // ROM data follows the address a cycle later, so go back through FETCH.
                            addr_q   <= addr_q + AW'(1);
                            tx_rdy_q <= 1'b0;
                            state_q  <= S_FETCH;
                        end else if (is_hex_d) begin
                            tx_data_q <= cur_char_d;
                            state_q   <= S_THEX;
                        end else begin
                            tx_data_q <= eol_first_d;
                            state_q   <= (EOL_LF_ONLY != 0) ? S_TLF : S_TCR;
                        end
                    end
                end
                S_THEX: begin
                    if (xfer_d) begin
                        if (idx_q == LAST_IDX) begin
                            tx_data_q <= eol_first_d;
                            state_q   <= (EOL_LF_ONLY != 0) ? S_TLF : S_TCR;
                        end else begin
                            idx_q     <= idx_inc_d;
                            tx_data_q <= nxt_char_d;
                        end
                    end
                end
                S_TCR: begin
                    if (xfer_d) begin
                        tx_data_q <= 8'h0A;
                        state_q   <= S_TLF;
                    end
                end
                S_TLF: begin
                    if (xfer_d) begin
                        tx_rdy_q  <= 1'b0;
                        res_rdy_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign res_rdy_r_o = res_rdy_q;
    assign addr_o      = addr_q;
    assign tx_rdy_t_o  = tx_rdy_q;
    assign tx_data_t_o = tx_data_q;
endmodule

// File: tb/tb_msg_gen_hex.sv
// Bench for msg_gen_hex: a 64-bit CR/LF instance and a 16-bit LF-only instance share
// one descriptor stream; captured byte lines are compared with a string-level model.
module tb_msg_gen_hex;
    localparam int AW = 7;
    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          res_rdy_t = 1'b0;
    logic [2:0]    res_mode = '0;
    logic [AW-1:0] res_start = '0;
    logic [AW-1:0] res_end = '0;
    logic [63:0]   res_val = '0;
    logic          tx_rdy_r = 1'b0;

    logic          rr0, rr1, tv0, tv1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0]    td0, td1, data0, data1;
    logic [7:0]    rom [0:127];

    always #5 clk = ~clk;

    assign data0 = rom[addr0];
    assign data1 = rom[addr1];

    msg_gen_hex #(.AW(AW), .DW(64), .EOL_LF_ONLY(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .res_rdy_t_i(res_rdy_t), .res_mode_i(res_mode),
        .res_start_i(res_start), .res_end_i(res_end), .res_val_i(res_val),
        .res_rdy_r_o(rr0), .addr_o(addr0), .data_i(data0),
        .tx_rdy_t_o(tv0), .tx_data_t_o(td0), .tx_rdy_r_i(tx_rdy_r)
    );

    msg_gen_hex #(.AW(AW), .DW(16), .EOL_LF_ONLY(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .res_rdy_t_i(res_rdy_t), .res_mode_i(res_mode),
        .res_start_i(res_start), .res_end_i(res_end), .res_val_i(res_val[15:0]),
        .res_rdy_r_o(rr1), .addr_o(addr1), .data_i(data1),
        .tx_rdy_t_o(tv1), .tx_data_t_o(td1), .tx_rdy_r_i(tx_rdy_r)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdy_pat = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // UART ready pattern: always, one cycle in three, or random.
    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            case (rdy_pat)
                0:       tx_rdy_r = 1'b1;
                1:       tx_rdy_r = (c % 3 == 0);
                default: tx_rdy_r = 1'($urandom_range(0, 1));
            endcase
        end
    end

    bq_t        q0, q1;
    logic       hold0 = 1'b0, hold1 = 1'b0;
    logic [7:0] pd0 = '0, pd1 = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold0 && tv0) chk("hold0", 64'(td0), 64'(pd0));
            if (hold1 && tv1) chk("hold1", 64'(td1), 64'(pd1));
            if (tv0 && tx_rdy_r) q0.push_back(td0);
            if (tv1 && tx_rdy_r) q1.push_back(td1);
        end
        hold0 = tv0 && !tx_rdy_r;
        hold1 = tv1 && !tx_rdy_r;
        pd0 = td0;
        pd1 = td1;
    end

    function automatic int span_len(input int start, input int stop);
        return ((stop - start) % 128 + 128) % 128 + 1;
    endfunction

    function automatic bq_t model(input logic [2:0] mode, input int start, input int stop,
                                  input logic [63:0] val, input int nd, input bit lf_only);
        bq_t q;
        bq_t digits;
        for (int i = 0; i < span_len(start, stop); i++) q.push_back(rom[(start + i) % 128]);
        if (mode == 3'd1 || mode == 3'd2) begin
            for (int i = 0; i < nd; i++) begin
                logic [3:0] nib;
                nib = 4'((val >> (4 * (nd - 1 - i))) & 64'hF);
                digits.push_back((nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h37 + 8'(nib));
            end
            if (mode == 3'd2)
                while (digits.size() > 1 && digits[0] == 8'h30) void'(digits.pop_front());
            foreach (digits[i]) q.push_back(digits[i]);
        end
        if (!lf_only) q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic compare(input string tag, input bq_t got, input bq_t exp);
        int n;
        chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic issue(input logic [2:0] mode, input int start, input int stop, input logic [63:0] val);
        int t = 0;
        while (!(rr0 && rr1) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) chk("idle_timeout", 64'd0, 64'd1);
        @(negedge clk);
        res_mode  = mode;
        res_start = AW'(start);
        res_end   = AW'(stop);
        res_val   = val;
        res_rdy_t = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        res_rdy_t = 1'b0;
        @(negedge clk);
        chk("acc_rdy0", 64'(rr0), 64'd0);
        chk("acc_rdy1", 64'(rr1), 64'd0);
        chk("acc_tv0", 64'(tv0), 64'd0);
        chk("acc_addr0", 64'(addr0), 64'(start));
        @(negedge clk);
        chk("first_tv0", 64'(tv0), 64'd1);
        chk("first_tv1", 64'(tv1), 64'd1);
    endtask

    task automatic wait_done(output int lat0, output int lat1);
        int t = 0;
        bit d0 = 0, d1 = 0;
        lat0 = -1;
        lat1 = -1;
        while (!(d0 && d1) && t < 4000) begin
            @(negedge clk);
            t++;
            if (!d0 && rr0) begin d0 = 1; lat0 = cyc - acc_cyc; end
            if (!d1 && rr1) begin d1 = 1; lat1 = cyc - acc_cyc; end
        end
        if (!(d0 && d1)) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_line(input logic [2:0] mode, input int start, input int stop, input logic [63:0] val);
        bq_t e0, e1;
        int  lat0, lat1, len;
        e0  = model(mode, start, stop, val, 16, 0);
        e1  = model(mode, start, stop, val, 4, 1);
        len = span_len(start, stop);
        q0.delete();
        q1.delete();
        issue(mode, start, stop, val);
        wait_done(lat0, lat1);
        compare("dw64", q0, e0);
        compare("dw16", q1, e1);
        if (rdy_pat == 0) begin
            chk("lat0", 64'(lat0), 64'(e0.size() + len));
            chk("lat1", 64'(lat1), 64'(e1.size() + len));
        end
        $display("line mode=%0d start=%02h end=%02h val=%016h pat=%0d bytes=%0d/%0d",
                 mode, start, stop, val, rdy_pat, q0.size(), q1.size());
    endtask

    initial begin
        bq_t e0, e1;
        int  lat0, lat1;
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom_range(32, 126));
        rom[16] = 8'h4F; rom[17] = 8'h4B; rom[18] = 8'h21;
        rom[32] = 8'h3D; rom[127] = 8'h58; rom[0] = 8'h59;

        #12;
        chk("rst_rdy0", 64'(rr0), 64'd1);
        chk("rst_tv0", 64'(tv0), 64'd0);
        chk("rst_td0", 64'(td0), 64'd0);
        chk("rst_addr0", 64'(addr0), 64'd0);
        chk("rst_rdy1", 64'(rr1), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        rdy_pat = 0;
        run_line(3'd0, 16, 18, 64'h0);
        run_line(3'd1, 32, 32, 64'h0000_0000_DEAD_BEEF);
        run_line(3'd2, 32, 32, 64'h00A5);
        run_line(3'd2, 32, 32, 64'h0);
        run_line(3'd2, 16, 16, 64'hF000_0000_0000_0001);
        run_line(3'd0, 127, 0, 64'h0);
        run_line(3'd5, 126, 1, 64'h1234);
        rdy_pat = 1;
        run_line(3'd1, 16, 18, 64'h0123_4567_89AB_CDEF);

        // Descriptor pulsed while busy must be ignored.
        e0 = model(3'd1, 16, 18, 64'h0000_0000_0000_C0DE, 16, 0);
        e1 = model(3'd1, 16, 18, 64'h0000_0000_0000_C0DE, 4, 1);
        q0.delete();
        q1.delete();
        issue(3'd1, 16, 18, 64'h0000_0000_0000_C0DE);
        repeat (5) @(negedge clk);
        chk("busy_rdy0", 64'(rr0), 64'd0);
        res_mode = 3'd0; res_start = 7'd0; res_end = 7'd5; res_val = 64'hFFFF;
        res_rdy_t = 1'b1;
        @(negedge clk);
        res_rdy_t = 1'b0;
        wait_done(lat0, lat1);
        compare("busy64", q0, e0);
        compare("busy16", q1, e1);
        repeat (20) @(negedge clk);
        chk("busy_extra0", 64'(q0.size()), 64'(e0.size()));
        chk("busy_extra1", 64'(q1.size()), 64'(e1.size()));
        $display("line busy-ignore bytes=%0d/%0d", q0.size(), q1.size());

        // Reset in the middle of the hex digits.
        rdy_pat = 0;
        q0.delete();
        q1.delete();
        issue(3'd1, 32, 32, 64'h1234_5678_9ABC_DEF0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tv0", 64'(tv0), 64'd0);
        chk("mid_rst_rdy0", 64'(rr0), 64'd1);
        chk("mid_rst_td0", 64'(td0), 64'd0);
        chk("mid_rst_addr0", 64'(addr0), 64'd0);
        chk("mid_rst_tv1", 64'(tv1), 64'd0);
        chk("mid_rst_rdy1", 64'(rr1), 64'd1);
        $display("line reset mid-hex after %0d/%0d bytes", q0.size(), q1.size());
        @(negedge clk);
        rst_n = 1'b1;
        run_line(3'd1, 16, 18, 64'h0000_0000_0000_ABCD);

        for (int n = 0; n < 25; n++) begin
            int          st;
            logic [63:0] v;
            rdy_pat = $urandom_range(0, 2);
            st = $urandom_range(0, 127);
            v  = {$urandom, $urandom} >> $urandom_range(0, 63);
            run_line(3'($urandom_range(0, 7)), st, (st + $urandom_range(0, 4)) % 128, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
